ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Single clock clk; reset rst_n asynchronous, active-low; no parameters.
REQ-002 clk  in  1  clock, all state on rising edge
REQ-003 rst_n  in  1  async active-low reset
REQ-004 id_pc  in  64  PC of instruction in EX
REQ-005 id_rdata1  in  64  register-file rs1 value
REQ-006 id_rdata2  in  64  register-file rs2 value
REQ-007 id_imm  in  64  sign-extended immediate
REQ-008 id_rs1, id_rs2, id_rd  in  5 each  register indices
REQ-009 id_funct  in  4  {funct7[5], funct3}
REQ-010 id_m  in  3  memory control, passed through
REQ-011 id_wb  in  2  writeback control, passed through; bit1 = RegWrite
REQ-012 id_alu_op  in  2  00 add, 01 sub, 10 R-type by funct, 11 multiply
REQ-013 id_alu_src  in  1  1 = operand B is id_imm
REQ-014 flush  in  1  squash instruction in EX
REQ-015 exmem_rd, memwb_rd  in  5 each  forwarding destinations
REQ-016 exmem_regwrite, memwb_regwrite  in  1 each  forwarding enables
REQ-017 exmem_result, memwb_data  in  64 each  forwarding values
REQ-018 stall  out  1  upstream SHALL hold ID/EX inputs while high
REQ-019 ex_branch_target  out  64  registered id_pc + (id_imm << 1)
REQ-020 ex_zero  out  1  registered (ALU result == 0)
REQ-021 ex_alu_result  out  64  registered ALU/multiply result
REQ-022 ex_write_data  out  64  registered forwarded rs2 value (store data)
REQ-023 ex_rd / ex_m / ex_wb  out  5/3/2  registered pass-through fields

Function
REQ-024 Forwarding SHALL select, per operand, exmem_result if exmem_regwrite and exmem_rd == rs != 0, else memwb_data if memwb_regwrite and memwb_rd == rs != 0, else id_rdata; EX/MEM wins when both match.
REQ-025 Operand B SHALL be id_imm when id_alu_src=1, else forwarded rs2; ex_write_data SHALL always be forwarded rs2.
REQ-026 alu_op 10 funct decode: 0000 add, 1000 sub, 0111 and, 0110 or, 0100 xor, 0001 sll, 0101 srl, 1101 sra (shamt = B[5:0]); any other code yields add.
REQ-027 All arithmetic SHALL be 64-bit modulo 2^64; no overflow flag.
REQ-028 Non-multiply ops SHALL have latency 1: outputs update on the rising edge ending the EX cycle; stall stays 0.
REQ-029 Multiply FSM states IDLE, BUSY, DONE: IDLE+op11 -> latch operands, count=0, go BUSY; BUSY -> one shift-add step per cycle, at count==63 go DONE; DONE -> load product low 64 bits, go IDLE.
REQ-030 stall SHALL be combinationally 1 in IDLE with op11 and throughout BUSY, 0 in DONE; one multiply therefore occupies 66 cycles, stall high 65.
REQ-031 While stall=1, output register SHALL load a bubble (ex_m=0, ex_wb=0, other outputs 0).
REQ-032 DONE SHALL not restart on the still-present op11; a new multiply needs a fresh IDLE cycle.
REQ-033 flush=1 SHALL load a bubble on that edge and force FSM to IDLE, aborting any multiply; flush wins over a simultaneous multiply start or DONE.

Reset
REQ-034 rst_n low SHALL immediately clear all registered outputs to 0, FSM to IDLE, count to 0, stall to 0.
REQ-035 Reset asserted mid-multiply SHALL discard the operation; first edge after release behaves as IDLE.

Configuration
REQ-036 Macro EX_MUL_EN defined: multiplier FSM per REQ-029..REQ-033 present.
REQ-037 EX_MUL_EN undefined: no FSM, alu_op 11 executes add in 1 cycle, stall tied 0.

Verification
REQ-038 alu_op=10 funct=1000, rdata1=5, rdata2=7 -> next edge ex_alu_result=0xFFFFFFFFFFFFFFFE, ex_zero=0.
REQ-039 id_rs1=3, exmem_rd=3 result=0x10, memwb_rd=3 data=0x20, both regwrite, alu_op=00, imm=1, alu_src=1 -> ex_alu_result=0x11.
REQ-040 EX_MUL_EN, op11, A=0x1_0000_0001, B=3 -> stall high 65 cycles, bubbles meanwhile, then ex_alu_result=0x3_0000_0003.
REQ-041 flush in BUSY cycle 10 -> bubble, stall 0 next cycle, FSM IDLE; following add completes in 1 cycle.
REQ-042 rst_n low mid-multiply -> outputs 0 immediately; after release, op11 restarts full 66-cycle sequence.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage with operand forwarding, a 64-bit ALU
// and a registered EX/MEM output bank.
// Optional feature macro: EX_MUL_EN. When it is defined, a shift-add
// multiplier FSM serves alu_op 11. When it is undefined, alu_op 11 is an
// add and stall is tied low.
// Handshake: stall is the only flow control. While it is high, upstream
// holds every id_* input stable and the output bank loads bubbles.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] id_pc,
  input  logic [63:0] id_rdata1,
  input  logic [63:0] id_rdata2,
  input  logic [63:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_funct,
  input  logic [2:0]  id_m,
  input  logic [1:0]  id_wb,
  input  logic [1:0]  id_alu_op,
  input  logic        id_alu_src,
  input  logic        flush,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic        exmem_regwrite,
  input  logic        memwb_regwrite,
  input  logic [63:0] exmem_result,
  input  logic [63:0] memwb_data,
  output logic        stall,
  output logic [63:0] ex_branch_target,
  output logic        ex_zero,
  output logic [63:0] ex_alu_result,
  output logic [63:0] ex_write_data,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_m,
  output logic [1:0]  ex_wb
);

  logic [63:0] w_fwd_a;
  logic [63:0] w_fwd_b;
  logic [63:0] w_op_b;
  logic [63:0] w_alu;
  logic [63:0] w_result;
  logic [5:0]  w_shamt;

  logic [63:0] r_branch_target;
  logic        r_zero;
  logic [63:0] r_alu_result;
  logic [63:0] r_write_data;
  logic [4:0]  r_rd;
  logic [2:0]  r_m;
  logic [1:0]  r_wb;

  // Forwarding: the MEM/WB match is applied first so that an EX/MEM match overrides it.
  always_comb begin
    w_fwd_a = id_rdata1;
    w_fwd_b = id_rdata2;
    if (memwb_regwrite && (memwb_rd == id_rs1) && (id_rs1 != 5'd0)) w_fwd_a = memwb_data;
    if (exmem_regwrite && (exmem_rd == id_rs1) && (id_rs1 != 5'd0)) w_fwd_a = exmem_result;
    if (memwb_regwrite && (memwb_rd == id_rs2) && (id_rs2 != 5'd0)) w_fwd_b = memwb_data;
    if (exmem_regwrite && (exmem_rd == id_rs2) && (id_rs2 != 5'd0)) w_fwd_b = exmem_result;
  end

  assign w_op_b  = id_alu_src ? id_imm : w_fwd_b;
  assign w_shamt = w_op_b[5:0];

  // Single-cycle ALU. Unlisted funct codes fall back to add, and so does alu_op 11.
  always_comb begin
    w_alu = w_fwd_a + w_op_b;
    case (id_alu_op)
      2'b01: w_alu = w_fwd_a - w_op_b;
      2'b10: begin
        case (id_funct)
          4'b1000: w_alu = w_fwd_a - w_op_b;
          4'b0111: w_alu = w_fwd_a & w_op_b;
          4'b0110: w_alu = w_fwd_a | w_op_b;
          4'b0100: w_alu = w_fwd_a ^ w_op_b;
          4'b0001: w_alu = w_fwd_a << w_shamt;
          4'b0101: w_alu = w_fwd_a >> w_shamt;
          4'b1101: w_alu = $signed(w_fwd_a) >>> w_shamt;
          default: w_alu = w_fwd_a + w_op_b;
        endcase
      end
      default: w_alu = w_fwd_a + w_op_b;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  mul_state_t  r_state;
  logic [5:0]  r_count;
  logic [63:0] r_mcand;
  logic [63:0] r_mplier;
  logic [63:0] r_prod;
  logic        w_mul_op;

  assign w_mul_op = (id_alu_op == 2'b11);
  // Reset gates stall low even while a multiply opcode is waiting in IDLE.
  assign stall    = rst_n & (((r_state == S_IDLE) & w_mul_op) | (r_state == S_BUSY));
  assign w_result = (r_state == S_DONE) ? r_prod : w_alu;

  // Multiplier FSM: latch operands, then 64 shift-add steps, then one DONE cycle.
  // flush returns it to IDLE from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= 6'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 64'd0;
      r_prod   <= 64'd0;
    end else if (flush) begin
      r_state  <= S_IDLE;
      r_count  <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_op) begin
            r_mcand  <= w_fwd_a;
            r_mplier <= w_op_b;
            r_prod   <= 64'd0;
            r_count  <= 6'd0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_prod   <= r_prod + (r_mplier[0] ? r_mcand : 64'd0);
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 6'd1;
          if (r_count == 6'd63) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign stall    = 1'b0;
  assign w_result = w_alu;
`endif

  // EX/MEM output bank: loads a bubble on flush or stall, otherwise the executed instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_target <= 64'd0;
      r_zero          <= 1'b0;
      r_alu_result    <= 64'd0;
      r_write_data    <= 64'd0;
      r_rd            <= 5'd0;
      r_m             <= 3'd0;
      r_wb            <= 2'd0;
    end else if (flush || stall) begin
      r_branch_target <= 64'd0;
      r_zero          <= 1'b0;
      r_alu_result    <= 64'd0;
      r_write_data    <= 64'd0;
      r_rd            <= 5'd0;
      r_m             <= 3'd0;
      r_wb            <= 2'd0;
    end else begin
      r_branch_target <= id_pc + (id_imm << 1);
      r_zero          <= (w_result == 64'd0);
      r_alu_result    <= w_result;
      r_write_data    <= w_fwd_b;
      r_rd            <= id_rd;
      r_m             <= id_m;
      r_wb            <= id_wb;
    end
  end

  assign ex_branch_target = r_branch_target;
  assign ex_zero          = r_zero;
  assign ex_alu_result    = r_alu_result;
  assign ex_write_data    = r_write_data;
  assign ex_rd            = r_rd;
  assign ex_m             = r_m;
  assign ex_wb            = r_wb;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed checks of ex_stage against a
// behavioural model. The multiply sequences are built only when EX_MUL_EN
// is defined.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [63:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic [2:0]  id_m;
  logic [1:0]  id_wb, id_alu_op;
  logic        id_alu_src, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regwrite, memwb_regwrite;
  logic [63:0] exmem_result, memwb_data;
  logic        stall;
  logic [63:0] ex_branch_target, ex_alu_result, ex_write_data;
  logic        ex_zero;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_m;
  logic [1:0]  ex_wb;

  int n_checks = 0;
  int n_pass   = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_m(id_m), .id_wb(id_wb), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .flush(flush), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_result(exmem_result), .memwb_data(memwb_data),
    .stall(stall), .ex_branch_target(ex_branch_target), .ex_zero(ex_zero),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_rd(ex_rd), .ex_m(ex_m), .ex_wb(ex_wb)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
  endtask

  // reference model
  function automatic logic [63:0] fwd(input logic [4:0] rs, input logic [63:0] rf);
    if (exmem_regwrite && exmem_rd == rs && rs != 0) return exmem_result;
    if (memwb_regwrite && memwb_rd == rs && rs != 0) return memwb_data;
    return rf;
  endfunction

  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] op, input logic [3:0] fn);
    logic signed [63:0] sa;
    int sh;
    sa = a;
    sh = int'(b % 64);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin
        case (fn)
          4'b1000: return a - b;
          4'b0111: return a & b;
          4'b0110: return a | b;
          4'b0100: return a ^ b;
          4'b0001: return a << sh;
          4'b0101: return a >> sh;
          4'b1101: return sa >>> sh;
          default: return a + b;
        endcase
      end
      default: return a + b;
    endcase
  endfunction

  // driver tasks
  task automatic clear_inputs();
    id_pc = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct = 0; id_m = 0; id_wb = 0;
    id_alu_op = 0; id_alu_src = 0; flush = 0;
    exmem_rd = 0; memwb_rd = 0; exmem_regwrite = 0; memwb_regwrite = 0;
    exmem_result = 0; memwb_data = 0;
  endtask

  task automatic rand_inputs(input bit allow_op3);
    logic [3:0] fn_tab [8];
    fn_tab = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101};
    id_pc     = {$urandom, $urandom};
    id_rdata1 = {$urandom, $urandom};
    id_rdata2 = ($urandom_range(0, 7) == 0) ? id_rdata1 : {$urandom, $urandom};
    id_imm    = {{32{1'b0}}, $urandom} - 64'h8000_0000;
    id_rs1    = 5'($urandom_range(0, 3));
    id_rs2    = 5'($urandom_range(0, 3));
    id_rd     = 5'($urandom_range(0, 31));
    id_funct  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : fn_tab[$urandom_range(0, 7)];
    id_m      = 3'($urandom_range(0, 7));
    id_wb     = 2'($urandom_range(0, 3));
    id_alu_op = 2'($urandom_range(0, allow_op3 ? 3 : 2));
    id_alu_src = 1'($urandom_range(0, 1));
    flush     = ($urandom_range(0, 9) == 0);
    exmem_rd  = 5'($urandom_range(0, 3));
    memwb_rd  = 5'($urandom_range(0, 3));
    exmem_regwrite = 1'($urandom_range(0, 1));
    memwb_regwrite = 1'($urandom_range(0, 1));
    exmem_result = {$urandom, $urandom};
    memwb_data   = {$urandom, $urandom};
  endtask

  // Scoreboard: predict from current inputs, clock once, compare the output bank.
  task automatic exec_check(input string tag);
    logic [63:0] a, b2, b, res, exp_bt, exp_wd, exp_ctl;
    logic exp_z;
    a  = fwd(id_rs1, id_rdata1);
    b2 = fwd(id_rs2, id_rdata2);
    b  = id_alu_src ? id_imm : b2;
    res = alu_model(a, b, id_alu_op, id_funct);
    exp_z = (res == 0);
    exp_bt = id_pc + id_imm * 2;
    exp_wd = b2;
    exp_ctl = {54'd0, id_rd, id_m, id_wb};
    if (flush) begin
      res = 0; exp_z = 0; exp_bt = 0; exp_wd = 0; exp_ctl = 0;
    end
    check({tag, "_stall"}, {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_result"}, ex_alu_result, res);
    check({tag, "_zero"}, {63'd0, ex_zero}, {63'd0, exp_z});
    check({tag, "_wdata"}, ex_write_data, exp_wd);
    check({tag, "_btgt"}, ex_branch_target, exp_bt);
    check({tag, "_ctl"}, {54'd0, ex_rd, ex_m, ex_wb}, exp_ctl);
  endtask

`ifdef EX_MUL_EN
  function automatic logic [63:0] out_or();
    return ex_alu_result | ex_write_data | ex_branch_target |
           {54'd0, ex_rd, ex_m, ex_wb} | {63'd0, ex_zero};
  endfunction

  // Full multiply: count stall-high cycles, expect bubbles meanwhile, then the product.
  task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b);
    int n_stall;
    int bad;
    logic [63:0] prod;
    clear_inputs();
    id_rdata1 = a; id_rdata2 = b; id_alu_op = 2'b11;
    id_rd = 5'd5; id_wb = 2'b10; id_m = 3'b001; id_pc = 64'h100;
    prod = a * b;
    n_stall = 0; bad = 0;
    while (stall === 1'b1 && n_stall < 80) begin
      n_stall++;
      @(posedge clk); #1;
      if (out_or() != 0) bad++;
    end
    check({tag, "_stall_cycles"}, 64'(n_stall), 64'd65);
    check({tag, "_bubbles"}, 64'(bad), 64'd0);
    @(posedge clk); #1;
    check({tag, "_product"}, ex_alu_result, prod);
    check({tag, "_ctl"}, {54'd0, ex_rd, ex_m, ex_wb}, {54'd0, 5'd5, 3'b001, 2'b10});
    // Replace the instruction so the FSM does not restart.
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    id_rdata1 = 64'h1234; id_pc = 64'h40; id_rd = 5'd7; id_wb = 2'b11;
    #12;
    check("reset_result", ex_alu_result, 64'd0);
    check("reset_ctl", {54'd0, ex_rd, ex_m, ex_wb}, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    check("reset_hold_btgt", ex_branch_target, 64'd0);
    rst_n = 1'b1;

    // Directed: 5 - 7 via R-type sub
    clear_inputs();
    id_alu_op = 2'b10; id_funct = 4'b1000; id_rdata1 = 64'd5; id_rdata2 = 64'd7;
    @(posedge clk); #1;
    check("sub_neg_result", ex_alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_neg_zero", {63'd0, ex_zero}, 64'd0);

    // Directed: both forwarding sources match, EX/MEM wins
    clear_inputs();
    id_rs1 = 5'd3; exmem_rd = 5'd3; exmem_result = 64'h10; memwb_rd = 5'd3; memwb_data = 64'h20;
    exmem_regwrite = 1; memwb_regwrite = 1; id_alu_op = 2'b00; id_imm = 64'd1; id_alu_src = 1;
    @(posedge clk); #1;
    check("fwd_prio_result", ex_alu_result, 64'h11);

    // Directed: x0 never forwards; zero flag on equal sub
    clear_inputs();
    id_rs1 = 5'd0; exmem_rd = 5'd0; exmem_regwrite = 1; exmem_result = 64'h99;
    id_rdata1 = 64'h42; id_rdata2 = 64'h42; id_alu_op = 2'b01;
    exec_check("x0_sub");

`ifndef EX_MUL_EN
    // alu_op 11 without multiplier is a single-cycle add
    clear_inputs();
    id_alu_op = 2'b11; id_rdata1 = 64'h1_0000_0001; id_rdata2 = 64'd3;
    exec_check("op3_add");
`endif

    for (int i = 0; i < 200; i++) begin
`ifdef EX_MUL_EN
      rand_inputs(1'b0);
`else
      rand_inputs(1'b1);
`endif
      exec_check($sformatf("rand%0d", i));
    end

`ifdef EX_MUL_EN
    run_mul("mul_dir", 64'h1_0000_0001, 64'd3);
    exec_check("after_mul");
    for (int k = 0; k < 3; k++) run_mul($sformatf("mul_rnd%0d", k), {$urandom, $urandom}, {$urandom, $urandom});

    // Flush in the tenth BUSY cycle aborts the multiply
    clear_inputs();
    id_alu_op = 2'b11; id_rdata1 = 64'd9; id_rdata2 = 64'd9;
    @(posedge clk); #1;
    for (int c = 0; c < 9; c++) begin @(posedge clk); #1; end
    check("flush_pre_stall", {63'd0, stall}, 64'd1);
    flush = 1'b1; id_rd = 5'd4; id_wb = 2'b10;
    @(posedge clk); #1;
    check("flush_bubble", out_or(), 64'd0);
    clear_inputs();
    id_rdata1 = 64'd100; id_rdata2 = 64'd23; id_rd = 5'd2;
    exec_check("flush_then_add");

    // Reset in the middle of a multiply, then a full restart
    clear_inputs();
    id_alu_op = 2'b11; id_rdata1 = 64'd6; id_rdata2 = 64'd7;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_mid_out", out_or(), 64'd0);
    check("rst_mid_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_mul("mul_after_rst", 64'd6, 64'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
